uart_tx_fifo: RTL and testbench

//  Buffered, run-time-configurable UART transmitter. A valid/ready write port fills an

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_fifo_sync_fifo.sv | 53 +++++
 rtl/uart_tx_fifo.sv | 144 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: parity modes, transmitter FSM states and the minimum frame width.
// Used by both the transmitter and the receiver so the two agree on encodings.
package uart_pkg;

  localparam int MIN_DATA_BITS = 5;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'd0,
    PAR_EVEN  = 2'd1,
    PAR_ODD   = 2'd2,
    PAR_NONE3 = 2'd3
  } parity_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } tx_state_e;

  function automatic logic parity_on(parity_e p);
    return (p == PAR_EVEN) || (p == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Show-ahead single-clock FIFO: pop_data is valid whenever empty=0; flags come from the count register.
// Push while full and pop while empty are ignored, so callers may hold requests.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed frame engine advancing one bit per baud_tick, LSB first.
// s_ready is !full from the registered count; frames run back-to-back while words are queued.
import uart_pkg::*;

module uart_tx_fifo #(
  parameter int MAX_DATA_BITS = 8,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               baud_tick,
  input  logic                               s_valid,
  input  logic [MAX_DATA_BITS-1:0]           s_data,
  output logic                               s_ready,
  input  logic [$clog2(MAX_DATA_BITS+1)-1:0] cfg_data_bits,
  input  logic [1:0]                         cfg_parity,
  input  logic                               cfg_stop2,
  output logic                               tx_pin,
  output logic                               tx_busy,
  output logic                               tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int LW = $clog2(MAX_DATA_BITS + 1);

  tx_state_e                state, state_nxt;
  logic [MAX_DATA_BITS-1:0] fifo_data;
  logic [MAX_DATA_BITS-1:0] masked;
  logic [MAX_DATA_BITS-1:0] shift;
  logic [LW-1:0]            len_cfg, len_q, idx;
  logic [1:0]               stop_cnt;
  logic                     fifo_full, fifo_empty;
  logic                     pop, load, stop_end;
  logic                     par_en_q, par_q, stop2_q, par_nxt;
  parity_e                  par_mode;

  sync_fifo #(
    .WIDTH (MAX_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (s_valid && s_ready),
    .push_data (s_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign s_ready  = !fifo_full;
  assign par_mode = parity_e'(cfg_parity);
  assign stop_end = (stop_cnt == (stop2_q ? 2'd2 : 2'd1));

  // Out-of-range lengths are clamped; parity covers only the bits actually sent.
  always_comb begin
    len_cfg = cfg_data_bits;
    if (cfg_data_bits < LW'(MIN_DATA_BITS)) len_cfg = LW'(MIN_DATA_BITS);
    else if (cfg_data_bits > LW'(MAX_DATA_BITS)) len_cfg = LW'(MAX_DATA_BITS);
  end

  always_comb begin
    masked = '0;
    for (int i = 0; i < MAX_DATA_BITS; i++) masked[i] = fifo_data[i] && (i < int'(len_cfg));
  end

  assign par_nxt = (^masked) ^ (par_mode == PAR_ODD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    if (baud_tick) begin
      case (state)
        IDLE: if (!fifo_empty) begin
          pop = 1'b1; load = 1'b1; state_nxt = DATA;
        end
        DATA:   if (idx == len_q - 1'b1) state_nxt = par_en_q ? PARITY : STOP;
        PARITY: state_nxt = STOP;
        STOP: if (stop_end) begin
          if (!fifo_empty) begin
            pop = 1'b1; load = 1'b1; state_nxt = DATA;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    tx_done = baud_tick && (state == STOP) && stop_end;
  end

  // A load (start bit) takes priority, which gives the gapless hand-off from the last stop bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift    <= '0;
      len_q    <= LW'(MIN_DATA_BITS);
      idx      <= '0;
      stop_cnt <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
      tx_pin   <= 1'b1;
      tx_busy  <= 1'b0;
    end else if (baud_tick) begin
      if (load) begin
        shift    <= fifo_data;
        len_q    <= len_cfg;
        par_en_q <= parity_on(par_mode);
        par_q    <= par_nxt;
        stop2_q  <= cfg_stop2;
        idx      <= '0;
        stop_cnt <= '0;
        tx_pin   <= 1'b0;
        tx_busy  <= 1'b1;
      end else begin
        case (state)
          DATA: begin
            tx_pin <= shift[0];
            shift  <= shift >> 1;
            idx    <= idx + 1'b1;
          end
          PARITY: tx_pin <= par_q;
          STOP: begin
            tx_pin   <= 1'b1;
            stop_cnt <= stop_cnt + 1'b1;
            if (stop_end) tx_busy <= 1'b0;
          end
          default: tx_pin <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: hand-computed bit streams checked tick by tick.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       baud_tick;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic [3:0] cfg_data_bits;
  logic [1:0] cfg_parity;
  logic       cfg_stop2;
  logic       tx_pin;
  logic       tx_busy;
  logic       tx_done;
  logic [4:0] fifo_count;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.MAX_DATA_BITS(8), .FIFO_DEPTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .baud_tick     (baud_tick),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .tx_pin        (tx_pin),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // One baud period: 15 quiet clocks then a one-clock tick; tx_done is sampled inside the tick cycle.
  task automatic tick(output logic pin, output logic busy, output logic done);
    repeat (15) @(negedge clk);
    baud_tick = 1'b1;
    #1 done = tx_done;
    @(negedge clk);
    baud_tick = 1'b0;
    pin  = tx_pin;
    busy = tx_busy;
  endtask

  task automatic run_frame(input string tag, input int n, input logic [15:0] bits,
                           input logic done_first, input int chg_at, input logic [1:0] new_par);
    logic p, b, d;
    for (int i = 0; i < n; i++) begin
      tick(p, b, d);
      check($sformatf("%s pin%0d", tag, i), 32'(p), 32'(bits[i]));
      check($sformatf("%s busy%0d", tag, i), 32'(b), 32'd1);
      check($sformatf("%s done%0d", tag, i), 32'(d), (i == 0) ? 32'(done_first) : 32'd0);
      if (i == chg_at) cfg_parity = new_par;
    end
  endtask

  task automatic end_idle(input string tag);
    logic p, b, d;
    tick(p, b, d);
    check({tag, " done_end"}, 32'(d), 32'd1);
    check({tag, " pin_end"}, 32'(p), 32'd1);
    check({tag, " busy_end"}, 32'(b), 32'd0);
  endtask

  // Expected 8N1 line sequence: start 0, data LSB first, stop 1.
  function automatic logic [15:0] f8n1(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  function automatic logic [7:0] word_k(input int k);
    return 8'(k * 37 + 3);
  endfunction

  initial begin
    logic p, b, d;
    reset         = 1'b1;
    baud_tick     = 1'b0;
    s_valid       = 1'b0;
    s_data        = 8'h00;
    cfg_data_bits = 4'd8;
    cfg_parity    = 2'd0;
    cfg_stop2     = 1'b0;
    #1;
    check("rst tx_pin", 32'(tx_pin), 32'd1);
    check("rst tx_busy", 32'(tx_busy), 32'd0);
    check("rst tx_done", 32'(tx_done), 32'd0);
    check("rst s_ready", 32'(s_ready), 32'd1);
    check("rst count", 32'(fifo_count), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
    push(8'hA5);
    check("t1 count", 32'(fifo_count), 32'd1);
    run_frame("t1", 10, 16'h034A, 1'b0, -1, 2'd0);
    end_idle("t1");

    // Length 0 clamps to 5: 0x1F -> 0,1,1,1,1,1,1
    cfg_data_bits = 4'd0;
    push(8'hFF);
    run_frame("clamp5", 7, 16'h007E, 1'b0, -1, 2'd0);
    end_idle("clamp5");
    cfg_data_bits = 4'd8;

    // 8O1 0xA5 parity 1, 8E1 0xA5 parity 0
    cfg_parity = 2'd2;
    push(8'hA5);
    run_frame("t2odd", 11, 16'h074A, 1'b0, -1, 2'd0);
    end_idle("t2odd");
    cfg_parity = 2'd1;
    push(8'hA5);
    run_frame("t2even", 11, 16'h054A, 1'b0, -1, 2'd0);
    end_idle("t2even");

    // 7E2 0x41 with bit 7 set: 0,1,0,0,0,0,0,1,0,1,1
    cfg_data_bits = 4'd7;
    cfg_stop2     = 1'b1;
    push(8'hC1);
    run_frame("t3", 11, 16'h0682, 1'b0, -1, 2'd0);
    end_idle("t3");
    cfg_data_bits = 4'd8;
    cfg_stop2     = 1'b0;

    // Parity switched to NONE mid-frame: first frame stays 8E1, second goes 8N1
    cfg_parity = 2'd1;
    push(8'hA5);
    push(8'h03);
    run_frame("t5a", 11, 16'h054A, 1'b0, 3, 2'd0);
    run_frame("t5b", 10, 16'h0206, 1'b1, -1, 2'd0);
    end_idle("t5b");

    // Fill with ticks stalled, 17th write refused, then drain back-to-back
    for (int k = 0; k < 16; k++) begin
      check($sformatf("t4 ready%0d", k), 32'(s_ready), 32'd1);
      push(word_k(k));
    end
    check("t4 count full", 32'(fifo_count), 32'd16);
    check("t4 ready full", 32'(s_ready), 32'd0);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 8'hEE;
    repeat (2) @(negedge clk);
    check("t4 count held", 32'(fifo_count), 32'd16);
    s_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      run_frame($sformatf("t4f%0d", k), 10, f8n1(word_k(k)), k > 0, -1, 2'd0);
      if (k == 0) begin
        check("t4 count after pop", 32'(fifo_count), 32'd15);
        check("t4 ready after pop", 32'(s_ready), 32'd1);
      end
    end
    end_idle("t4");
    check("t4 count empty", 32'(fifo_count), 32'd0);

    // Reset during data bit 3 with 3 words still queued
    push(8'h00);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    for (int i = 0; i < 5; i++) tick(p, b, d);
    check("t6 pin bit3", 32'(tx_pin), 32'd0);
    check("t6 count pre", 32'(fifo_count), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("t6 pin async", 32'(tx_pin), 32'd1);
    check("t6 count", 32'(fifo_count), 32'd0);
    check("t6 ready", 32'(s_ready), 32'd1);
    check("t6 busy", 32'(tx_busy), 32'd0);
    check("t6 done", 32'(tx_done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tick(p, b, d);
    check("t6 idle pin", 32'(p), 32'd1);
    check("t6 idle busy", 32'(b), 32'd0);
    check("t6 idle done", 32'(d), 32'd0);
    push(8'h5A);
    run_frame("t6new", 10, f8n1(8'h5A), 1'b0, -1, 2'd0);
    end_idle("t6new");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
